bp_table_ctrl: RTL

- Owns and sequences a table of 2^IDX_W two-bit branch predictor counters.
- Serves one prediction lookup per cycle and applies resolved branch outcomes from a small update queue.
- Clears the table with an initialization sweep after reset.
- Sits between fetch (lookup) and execute (resolution), and replaces the single standalone 2-bit predictor with an indexed, scheduled table.

---
 rtl/bp_pkg.sv | 30 +++
 rtl/bp_upd_fifo.sv | 53 +++++
 rtl/bp_table_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared types for the branch predictor table controller: counter encoding,
// controller states and the 2-bit counter transition function.
package bp_pkg;

  typedef logic [1:0] cnt_t;

  localparam cnt_t SNT = 2'b00;
  localparam cnt_t WNT = 2'b01;
  localparam cnt_t WT  = 2'b10;
  localparam cnt_t ST  = 2'b11;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // A taken outcome from either weak state jumps straight to ST, and a
  // not-taken outcome from either weak state falls straight to SNT.
  function automatic cnt_t bp_next(input cnt_t cnt, input logic taken);
    cnt_t nxt;
    case (cnt)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? ST  : SNT;
      WT:      nxt = taken ? ST  : SNT;
      default: nxt = taken ? ST  : WT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Update queue for resolved branches: power-of-two depth FIFO with
// wrapping pointers and an occupancy counter one bit wider than the pointers.
module bp_upd_fifo #(
  parameter int W     = 5,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/bp_table_ctrl.sv
// Indexed 2-bit branch predictor table: init sweep, 1-cycle lookup with
// write-first bypass, queued updates. Define GSHARE_EN to XOR global history into the index.
//
// state | meaning
// INIT  | sweeping WNT into every entry, lookups and updates refused
// RUN   | serving lookups, draining one queued update per cycle
module bp_table_ctrl
  import bp_pkg::*;
#(
  parameter int IDX_W     = 4,
  parameter int PC_W      = 8,
  parameter int UPD_DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pred_req,
  input  logic [PC_W-1:0]  pred_pc,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             upd_valid,
  output logic             upd_ready,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  output logic             init_busy
);

  localparam int N = 1 << IDX_W;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ptr_nxt;
  cnt_t             tbl [N];

  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  logic [IDX_W:0]   fifo_din;
  logic [IDX_W:0]   fifo_dout;
  logic [IDX_W-1:0] head_idx;
  logic             head_taken;
  cnt_t             head_new;

  logic             tbl_we;
  logic [IDX_W-1:0] tbl_waddr;
  cnt_t             tbl_wdata;
  logic [IDX_W-1:0] lk_idx;
  cnt_t             lk_cnt;

  assign upd_ready = !fifo_full && (state == RUN);
  assign init_busy = (state == INIT);
  assign fifo_push = upd_valid && upd_ready;
  assign fifo_din  = {upd_idx, upd_taken};

  bp_upd_fifo #(
    .W     (IDX_W + 1),
    .DEPTH (UPD_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_idx   = fifo_dout[IDX_W:1];
  assign head_taken = fifo_dout[0];
  assign head_new   = bp_next(tbl[head_idx], head_taken);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= INIT;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    tbl_we    = 1'b0;
    tbl_waddr = head_idx;
    tbl_wdata = head_new;
    fifo_pop  = 1'b0;
    case (state)
      INIT: begin
        tbl_we    = 1'b1;
        tbl_waddr = ptr;
        tbl_wdata = WNT;
        ptr_nxt   = ptr + 1'b1;
        if (&ptr) state_nxt = RUN;
      end
      RUN: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          tbl_we   = 1'b1;
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (tbl_we) tbl[tbl_waddr] <= tbl_wdata;
  end

`ifdef GSHARE_EN
  logic [IDX_W-1:0] ghr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        ghr <= '0;
    else if (fifo_pop) ghr <= {ghr[IDX_W-2:0], head_taken};
  end

  assign lk_idx = pred_pc[IDX_W+1:2] ^ ghr;
`else
  assign lk_idx = pred_pc[IDX_W+1:2];
`endif

  logic unused_pc;
  assign unused_pc = ^{pred_pc[PC_W-1:IDX_W+2], pred_pc[1:0]};

  // Write-first: a lookup hitting the entry being updated this edge sees the new value.
  assign lk_cnt = (tbl_we && (state == RUN) && (tbl_waddr == lk_idx)) ? tbl_wdata
                                                                       : tbl[lk_idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_idx   <= '0;
    end else if ((state == RUN) && pred_req) begin
      pred_valid <= 1'b1;
      pred_taken <= lk_cnt[1];
      pred_idx   <= lk_idx;
    end else begin
      pred_valid <= 1'b0;
    end
  end

endmodule
